emif_pattern_checker: RTL and testbench

Parametrised write-pattern generator and read-back checker for EMIF Avalon-MM bring-up. It sits between the test sequencer (which issues the Avalon write/read commands) and the EMIF user port. It drives `amm_wrdata` with a deterministic pattern for one burst, regenerates the same pattern independently for the read-back burst, and compares every returned beat. It reports pass/fail, a saturating mismatch count and the index of the first failing beat.

---
 rtl/emif_pattern_checker.sv | 166 ++++++++++++++++
 tb/tb_emif_pattern_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_pattern_checker.sv
// ============================================================================
//  Module      : emif_pattern_checker
//  Description : EMIF Avalon-MM bring-up write-pattern generator and read-back
//                checker with pass/fail, saturating error count and first-error
//                beat index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emif_pattern_checker #(
    parameter int                DATA_W    = 320,
    parameter int                BURST_LEN = 144,
    parameter int                CNT_W     = 20,
    parameter int                MODE      = 0,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(579),
    parameter logic [DATA_W-1:0] STEP      = DATA_W'(100)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_wr_beat,
    input  logic              i_amm_rddatavalid,
    input  logic [DATA_W-1:0] i_amm_rddata,
    output logic [DATA_W-1:0] o_amm_wrdata,
    output logic              o_wr_active,
    output logic              o_rd_active,
    output logic              o_done,
    output logic              o_pass,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic              o_err_seen,
    output logic [CNT_W-1:0]  o_first_err_idx,
    output logic              o_stray
);

    localparam int               c_LANES = DATA_W / 32;
    localparam logic [31:0]      c_TAPS  = 32'h8020_0003;
    localparam logic [31:0]      c_L0    = (SEED[31:0] == 32'd0) ? 32'd1 : SEED[31:0];
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_next_state;

    logic [DATA_W-1:0] r_wrdata;
    logic [DATA_W-1:0] r_exp;
    logic [CNT_W-1:0]  r_wr_idx;
    logic [CNT_W-1:0]  r_rd_idx;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_first_err_idx;
    logic              r_err_seen;
    logic              r_stray;

    logic [DATA_W-1:0] w_p0;
    logic              w_start_acc;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_mismatch;

    function automatic logic [DATA_W-1:0] f_lanes(input logic [31:0] l);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < c_LANES; i++) begin
            v[32*i +: 32] = l ^ 32'(i);
        end
        return v;
    endfunction

    function automatic logic [31:0] f_lfsr(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? c_TAPS : 32'h0);
    endfunction

    // Lane 0 of an LFSR pattern word is the LFSR state itself, so the word
    // alone is enough to derive its successor.
    function automatic logic [DATA_W-1:0] f_next(input logic [DATA_W-1:0] cur);
        if (MODE == 0) begin
            return cur + STEP;
        end
        return f_lanes(f_lfsr(cur[31:0]));
    endfunction

    assign w_p0        = (MODE == 0) ? SEED : f_lanes(c_L0);
    assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_wr_acc    = (r_state == S_WRITE) && i_wr_beat;
    assign w_rd_acc    = (r_state == S_READ) && i_amm_rddatavalid;
    assign w_mismatch  = (i_amm_rddata != r_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_WRITE;
            S_WRITE: if (i_wr_beat && (r_wr_idx == c_LAST)) w_next_state = S_READ;
            S_READ:  if (i_amm_rddatavalid && (r_rd_idx == c_LAST)) w_next_state = S_DONE;
            S_DONE:  if (i_start) w_next_state = S_WRITE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrdata        <= '0;
            r_exp           <= '0;
            r_wr_idx        <= '0;
            r_rd_idx        <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_err_seen      <= 1'b0;
            r_stray         <= 1'b0;
        end else if (w_start_acc) begin
            r_wrdata        <= w_p0;
            r_exp           <= w_p0;
            r_wr_idx        <= '0;
            r_rd_idx        <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_err_seen      <= 1'b0;
            r_stray         <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wrdata <= f_next(r_wrdata);
                r_wr_idx <= r_wr_idx + CNT_W'(1);
            end
            if (w_rd_acc) begin
                r_exp    <= f_next(r_exp);
                r_rd_idx <= r_rd_idx + CNT_W'(1);
                if (w_mismatch) begin
                    if (r_err_cnt != {CNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                    if (!r_err_seen) begin
                        r_first_err_idx <= r_rd_idx;
                        r_err_seen      <= 1'b1;
                    end
                end
            end
            if (i_amm_rddatavalid && (r_state != S_READ)) begin
                r_stray <= 1'b1;
            end
        end
    end

    assign o_amm_wrdata    = r_wrdata;
    assign o_wr_active     = (r_state == S_WRITE);
    assign o_rd_active     = (r_state == S_READ);
    assign o_done          = (r_state == S_DONE);
    assign o_pass          = (r_state == S_DONE) && (r_err_cnt == '0) && !r_stray;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_seen      = r_err_seen;
    assign o_first_err_idx = r_first_err_idx;
    assign o_stray         = r_stray;

endmodule

`default_nettype wire

// File: tb/tb_emif_pattern_checker.sv
// ============================================================================
//  Module      : tb_emif_pattern_checker
//  Description : Self-checking bench for emif_pattern_checker (three configs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_emif_pattern_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // u0: incrementing, 320-bit, 8 beats
    logic         s0_start = 0, s0_wr = 0, s0_rdv = 0;
    logic [319:0] s0_rd = '0;
    logic [319:0] o0_wrdata;
    logic         o0_wa, o0_ra, o0_done, o0_pass, o0_seen, o0_stray;
    logic [19:0]  o0_err, o0_first;

    // u1: LFSR, 64-bit, 16 beats
    logic         s1_start = 0, s1_wr = 0, s1_rdv = 0;
    logic [63:0]  s1_rd = '0;
    logic [63:0]  o1_wrdata;
    logic         o1_wa, o1_ra, o1_done, o1_pass, o1_seen, o1_stray;
    logic [19:0]  o1_err, o1_first;

    // u2: incrementing, 32-bit, 7 beats, 3-bit counters
    logic         s2_start = 0, s2_wr = 0, s2_rdv = 0;
    logic [31:0]  s2_rd = '0;
    logic [31:0]  o2_wrdata;
    logic         o2_wa, o2_ra, o2_done, o2_pass, o2_seen, o2_stray;
    logic [2:0]   o2_err, o2_first;

    emif_pattern_checker #(.DATA_W(320), .BURST_LEN(8), .CNT_W(20), .MODE(0),
                           .SEED(320'd579), .STEP(320'd100)) u0 (
        .clk(clk), .rst_n(rst_n), .i_start(s0_start), .i_wr_beat(s0_wr),
        .i_amm_rddatavalid(s0_rdv), .i_amm_rddata(s0_rd), .o_amm_wrdata(o0_wrdata),
        .o_wr_active(o0_wa), .o_rd_active(o0_ra), .o_done(o0_done), .o_pass(o0_pass),
        .o_err_cnt(o0_err), .o_err_seen(o0_seen), .o_first_err_idx(o0_first),
        .o_stray(o0_stray));

    emif_pattern_checker #(.DATA_W(64), .BURST_LEN(16), .CNT_W(20), .MODE(1),
                           .SEED(64'd1), .STEP(64'd100)) u1 (
        .clk(clk), .rst_n(rst_n), .i_start(s1_start), .i_wr_beat(s1_wr),
        .i_amm_rddatavalid(s1_rdv), .i_amm_rddata(s1_rd), .o_amm_wrdata(o1_wrdata),
        .o_wr_active(o1_wa), .o_rd_active(o1_ra), .o_done(o1_done), .o_pass(o1_pass),
        .o_err_cnt(o1_err), .o_err_seen(o1_seen), .o_first_err_idx(o1_first),
        .o_stray(o1_stray));

    emif_pattern_checker #(.DATA_W(32), .BURST_LEN(7), .CNT_W(3), .MODE(0),
                           .SEED(32'd5), .STEP(32'd3)) u2 (
        .clk(clk), .rst_n(rst_n), .i_start(s2_start), .i_wr_beat(s2_wr),
        .i_amm_rddatavalid(s2_rdv), .i_amm_rddata(s2_rd), .o_amm_wrdata(o2_wrdata),
        .o_wr_active(o2_wa), .o_rd_active(o2_ra), .o_done(o2_done), .o_pass(o2_pass),
        .o_err_cnt(o2_err), .o_err_seen(o2_seen), .o_first_err_idx(o2_first),
        .o_stray(o2_stray));

    typedef struct {
        logic [7:0] plus1;
        logic [7:0] zero;
        bit         gaps;
        bit         rdv_on_start;
        int         exp_err;
        int         exp_first;
        bit         exp_seen;
        bit         exp_pass;
    } vec_t;

    vec_t tbl[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [319:0] p0(input int k);
        return 320'd579 + 320'(100 * k);
    endfunction

    task automatic run0(input vec_t v);
        logic [319:0] d;
        s0_start = 1; s0_rdv = v.rdv_on_start;
        tick;
        s0_start = 0; s0_rdv = 0;
        chk("u0 wr_active", 320'(o0_wa), 1);
        for (int k = 0; k < 8; k++) begin
            if (v.gaps) repeat ($urandom_range(0, 2)) tick;
            chk("u0 wrdata", o0_wrdata, p0(k));
            s0_wr = 1; tick; s0_wr = 0;
        end
        chk("u0 rd_active", 320'(o0_ra), 1);
        for (int k = 0; k < 8; k++) begin
            if (v.gaps) repeat ($urandom_range(0, 2)) tick;
            d = p0(k);
            if (v.plus1[k]) d = d + 320'd1;
            if (v.zero[k])  d = '0;
            s0_rdv = 1; s0_rd = d; tick; s0_rdv = 0;
        end
        chk("u0 done",      320'(o0_done),  1);
        chk("u0 err_cnt",   320'(o0_err),   320'(v.exp_err));
        chk("u0 first_idx", 320'(o0_first), 320'(v.exp_first));
        chk("u0 err_seen",  320'(o0_seen),  320'(v.exp_seen));
        chk("u0 stray",     320'(o0_stray), 0);
        chk("u0 pass",      320'(o0_pass),  320'(v.exp_pass));
    endtask

    task automatic run1(input bit corrupt_en);
        logic [31:0] l;
        logic [63:0] pat[16];
        logic [63:0] d, x;
        int          m_err, m_first;
        bit          m_seen;
        l = 32'd1;
        for (int k = 0; k < 16; k++) begin
            pat[k] = {l ^ 32'd1, l};
            l = (l >> 1) ^ (((l % 2) == 1) ? 32'h8020_0003 : 32'h0);
        end
        m_err = 0; m_first = 0; m_seen = 0;
        s1_start = 1; tick; s1_start = 0;
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            chk("u1 wrdata", 320'(o1_wrdata), 320'(pat[k]));
            s1_wr = 1; tick; s1_wr = 0;
        end
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            d = pat[k];
            if (corrupt_en && ($urandom_range(0, 3) == 0)) begin
                x = {$urandom, $urandom};
                if (x == 64'd0) x = 64'd1;
                d = d ^ x;
                if (!m_seen) begin m_seen = 1; m_first = k; end
                m_err++;
            end
            s1_rdv = 1; s1_rd = d; tick; s1_rdv = 0;
        end
        chk("u1 done",      320'(o1_done),  1);
        chk("u1 err_cnt",   320'(o1_err),   320'(m_err));
        chk("u1 first_idx", 320'(o1_first), 320'(m_first));
        chk("u1 err_seen",  320'(o1_seen),  320'(m_seen));
        chk("u1 pass",      320'(o1_pass),  320'(m_err == 0));
    endtask

    initial begin
        tbl[0] = '{8'h00, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{8'h20, 8'h40, 0, 0, 2, 5, 1, 0};
        tbl[2] = '{8'h00, 8'h00, 1, 1, 0, 0, 0, 1};
        tbl[3] = '{8'h80, 8'h00, 1, 0, 1, 7, 1, 0};
        tbl[4] = '{8'h00, 8'hFF, 0, 0, 8, 0, 1, 0};
        tbl[5] = '{8'h0C, 8'h00, 1, 0, 2, 2, 1, 0};

        repeat (2) tick;
        rst_n = 1;
        tick;
        chk("reset wrdata",    o0_wrdata, 0);
        chk("reset wr_active", 320'(o0_wa), 0);
        chk("reset rd_active", 320'(o0_ra), 0);
        chk("reset done",      320'(o0_done), 0);
        chk("reset pass",      320'(o0_pass), 0);
        chk("reset err_cnt",   320'(o0_err), 0);
        chk("reset err_seen",  320'(o0_seen), 0);
        chk("reset first_idx", 320'(o0_first), 0);
        chk("reset stray",     320'(o0_stray), 0);

        for (int i = 0; i < 6; i++) run0(tbl[i]);

        // Stray beat during WRITE, ignored start and wr_beat during READ
        s0_start = 1; tick; s0_start = 0;
        for (int k = 0; k < 8; k++) begin
            s0_wr = 1; s0_rdv = (k == 3); tick; s0_wr = 0; s0_rdv = 0;
        end
        chk("stray set", 320'(o0_stray), 1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                s0_start = 1; s0_wr = 1; tick; s0_start = 0; s0_wr = 0;
                chk("start ignored rd_active", 320'(o0_ra), 1);
                chk("start ignored wr_active", 320'(o0_wa), 0);
            end
            s0_rdv = 1; s0_rd = p0(k); tick; s0_rdv = 0;
        end
        chk("stray done",    320'(o0_done), 1);
        chk("stray err_cnt", 320'(o0_err), 0);
        chk("stray pass",    320'(o0_pass), 0);
        chk("stray held",    320'(o0_stray), 1);

        // Reset after three (wrong) read beats
        s0_start = 1; tick; s0_start = 0;
        for (int k = 0; k < 8; k++) begin s0_wr = 1; tick; s0_wr = 0; end
        for (int k = 0; k < 3; k++) begin s0_rdv = 1; s0_rd = '0; tick; s0_rdv = 0; end
        chk("pre-reset err_cnt", 320'(o0_err), 3);
        rst_n = 0;
        #1;
        chk("async reset rd_active", 320'(o0_ra), 0);
        chk("async reset err_cnt",   320'(o0_err), 0);
        chk("async reset err_seen",  320'(o0_seen), 0);
        chk("async reset wrdata",    o0_wrdata, 0);
        tick;
        rst_n = 1;
        tick;
        chk("post-reset wr_active", 320'(o0_wa), 0);
        chk("post-reset done",      320'(o0_done), 0);
        chk("post-reset wrdata",    o0_wrdata, 0);
        run0(tbl[0]);

        run1(0);
        for (int t = 0; t < 5; t++) run1(1);

        // Saturation with 3-bit counter
        s2_start = 1; tick; s2_start = 0;
        for (int k = 0; k < 7; k++) begin
            chk("u2 wrdata", 320'(o2_wrdata), 320'(32'(5 + 3 * k)));
            s2_wr = 1; tick; s2_wr = 0;
        end
        for (int k = 0; k < 7; k++) begin
            s2_rdv = 1; s2_rd = ~32'(5 + 3 * k); tick; s2_rdv = 0;
            if (k == 2) chk("u2 err_cnt mid", 320'(o2_err), 3);
        end
        chk("u2 done",      320'(o2_done), 1);
        chk("u2 err_cnt",   320'(o2_err), 7);
        chk("u2 first_idx", 320'(o2_first), 0);
        chk("u2 err_seen",  320'(o2_seen), 1);
        chk("u2 pass",      320'(o2_pass), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
